// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
// store_pkg : shared FSM state type and default sizing for the store blocks
// Revision  : 1.0
// ============================================================================
package store_pkg;

    localparam int CNT_W_DFLT        = 5;
    localparam int MAX_OCC_DFLT      = 20;
    localparam int DEBOUNCE_CYC_DFLT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_IN  = 2'd1,
        SERVE_OUT = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// sensor_debounce : 2-flop synchroniser, debounced clean level, rise pulse
// Revision        : 1.0
// ============================================================================
module sensor_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic rise
);

    localparam int              DB_W    = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic [1:0]      sync_d, sync_q;
    logic            clean_d, clean_q;
    logic            clean_prev_d, clean_prev_q;
    logic [DB_W-1:0] db_cnt_d, db_cnt_q;

    always_comb begin
        sync_d       = {sync_q[0], raw_in};
        clean_d      = clean_q;
        clean_prev_d = clean_q;
        db_cnt_d     = '0;
        // The DEBOUNCE_CYC-th consecutive differing sample flips the level.
        if (sync_q[1] != clean_q) begin
            if (db_cnt_q == DB_LAST) begin
                clean_d = ~clean_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            clean_q      <= 1'b0;
            clean_prev_q <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            sync_q       <= sync_d;
            clean_q      <= clean_d;
            clean_prev_q <= clean_prev_d;
            db_cnt_q     <= db_cnt_d;
        end
    end

    assign rise = clean_q & ~clean_prev_q;

endmodule
`default_nettype wire

// File: rtl/store_occupancy_ctrl.sv
`default_nettype none
// ============================================================================
// store_occupancy_ctrl : debounced entry/exit arbitration and occupancy count
// Revision             : 1.0
// ============================================================================
module store_occupancy_ctrl
    import store_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DFLT,
    parameter int MAX_OCC      = MAX_OCC_DFLT,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pressure_in,
    input  logic             pressure_out,
    output logic [CNT_W-1:0] count,
    output logic             door_lock,
    output logic             empty,
    output logic             in_ack,
    output logic             out_ack,
    output logic             in_reject,
    output logic             out_err,
    output logic             evt_lost
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OCC);

    logic             in_rise, out_rise;
    state_e           state_d, state_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             in_pend_d, in_pend_q;
    logic             out_pend_d, out_pend_q;
    logic             last_out_d, last_out_q;
    logic             evt_lost_d, evt_lost_q;
    logic             clr_in, clr_out;

    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_in (
        .clk    (clk),
        .reset  (reset),
        .raw_in (pressure_in),
        .rise   (in_rise)
    );

    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_out (
        .clk    (clk),
        .reset  (reset),
        .raw_in (pressure_out),
        .rise   (out_rise)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        last_out_d = last_out_q;
        clr_in     = 1'b0;
        clr_out    = 1'b0;
        in_ack     = 1'b0;
        out_ack    = 1'b0;
        in_reject  = 1'b0;
        out_err    = 1'b0;

        case (state_q)
            IDLE: begin
                // On contention serve whichever direction did not go last.
                if (in_pend_q && out_pend_q) begin
                    state_d = last_out_q ? SERVE_IN : SERVE_OUT;
                end else if (in_pend_q) begin
                    state_d = SERVE_IN;
                end else if (out_pend_q) begin
                    state_d = SERVE_OUT;
                end
            end
            SERVE_IN: begin
                if (count_q < CNT_MAX) begin
                    in_ack  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    in_reject = 1'b1;
                end
                clr_in     = 1'b1;
                last_out_d = 1'b0;
                state_d    = IDLE;
            end
            SERVE_OUT: begin
                if (count_q != '0) begin
                    out_ack = 1'b1;
                    count_d = count_q - CNT_W'(1);
                end else begin
                    out_err = 1'b1;
                end
                clr_out    = 1'b1;
                last_out_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_pend_d  = in_rise  | (in_pend_q  & ~clr_in);
        out_pend_d = out_rise | (out_pend_q & ~clr_out);
        evt_lost_d = evt_lost_q
                   | (in_rise  & in_pend_q  & ~clr_in)
                   | (out_rise & out_pend_q & ~clr_out);

        // An interrupted service must not be reported as done.
        if (reset) begin
            in_ack    = 1'b0;
            out_ack   = 1'b0;
            in_reject = 1'b0;
            out_err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            in_pend_q  <= 1'b0;
            out_pend_q <= 1'b0;
            last_out_q <= 1'b0;
            evt_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            in_pend_q  <= in_pend_d;
            out_pend_q <= out_pend_d;
            last_out_q <= last_out_d;
            evt_lost_q <= evt_lost_d;
        end
    end

    assign count     = count_q;
    assign door_lock = (count_q == CNT_MAX);
    assign empty     = (count_q == '0);
    assign evt_lost  = evt_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_store_occupancy_ctrl.sv
`default_nettype none
// ============================================================================
// tb_store_occupancy_ctrl : scoreboard bench with a transaction-level model
// Revision                : 1.0
// ============================================================================
module tb_store_occupancy_ctrl;

    localparam int CNT_W   = 5;
    localparam int MAX_OCC = 3;
    localparam int DEB     = 4;
    localparam int WIN     = 32;

    typedef enum int {EV_IN_ACK, EV_IN_REJ, EV_OUT_ACK, EV_OUT_ERR} ev_e;
    typedef struct {
        ev_e kind;
        int  cyc;
        int  pre;
        int  post;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             pressure_in;
    logic             pressure_out;
    logic [CNT_W-1:0] count;
    logic             door_lock, empty, in_ack, out_ack, in_reject, out_err, evt_lost;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   model_occ = 0;
    bit   model_last_out = 1'b0;

    store_occupancy_ctrl #(
        .CNT_W        (CNT_W),
        .MAX_OCC      (MAX_OCC),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pressure_in  (pressure_in),
        .pressure_out (pressure_out),
        .count        (count),
        .door_lock    (door_lock),
        .empty        (empty),
        .in_ack       (in_ack),
        .out_ack      (out_ack),
        .in_reject    (in_reject),
        .out_err      (out_err),
        .evt_lost     (evt_lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: one served press per call, in service order.
    task automatic model_in(input int t);
        exp_t e;
        e.kind = (model_occ < MAX_OCC) ? EV_IN_ACK : EV_IN_REJ;
        e.cyc  = t;
        e.pre  = model_occ;
        if (model_occ < MAX_OCC) model_occ++;
        e.post = model_occ;
        model_last_out = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic model_out(input int t);
        exp_t e;
        e.kind = (model_occ > 0) ? EV_OUT_ACK : EV_OUT_ERR;
        e.cyc  = t;
        e.pre  = model_occ;
        if (model_occ > 0) model_occ--;
        e.post = model_occ;
        model_last_out = 1'b1;
        exp_q.push_back(e);
    endtask

    function automatic logic [WIN-1:0] press(input int n);
        logic [WIN-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [WIN-1:0] dropout_press();
        logic [WIN-1:0] v;
        v = '0;
        for (int i = 0; i < 14; i++) v[i] = (i < 5) || (i % 3 != 0);
        return v;
    endfunction

    task automatic drive(input logic [WIN-1:0] pin, input logic [WIN-1:0] pout);
        for (int i = 0; i < WIN; i++) begin
            pressure_in  = pin[i];
            pressure_out = pout[i];
            @(negedge clk);
        end
        pressure_in  = 1'b0;
        pressure_out = 1'b0;
    endtask

    // kind: 0 entry, 1 exit, 2 both together, 3 entry glitch, 4 exit glitch, 5 entry with dropouts
    task automatic txn(input int kind, input int len_a, input int len_b);
        int             t0;
        logic [WIN-1:0] pin, pout;
        t0   = cyc;
        pin  = '0;
        pout = '0;
        case (kind)
            0: begin pin = press(len_a); model_in(t0 + 8); end
            1: begin pout = press(len_a); model_out(t0 + 8); end
            2: begin
                pin  = press(len_a);
                pout = press(len_b);
                if (model_last_out) begin model_in(t0 + 8); model_out(t0 + 10); end
                else begin model_out(t0 + 8); model_in(t0 + 10); end
            end
            3: pin  = press(len_a);
            4: pout = press(len_a);
            default: begin pin = dropout_press(); model_in(t0 + 8); end
        endcase
        drive(pin, pout);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        pressure_in  = 1'b0;
        pressure_out = 1'b0;
        repeat (3) @(negedge clk);
        reset          = 1'b0;
        model_occ      = 0;
        model_last_out = 1'b0;
    endtask

    // Monitor: every served pulse is matched against the next expected event.
    initial begin
        ev_e  got;
        exp_t e;
        forever begin
            @(negedge clk);
            if (in_ack || in_reject || out_ack || out_err) begin
                got = in_ack ? EV_IN_ACK : in_reject ? EV_IN_REJ : out_ack ? EV_OUT_ACK : EV_OUT_ERR;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(got), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", int'(got), int'(e.kind));
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_onehot", $countones({in_ack, in_reject, out_ack, out_err}), 1);
                    check("count_pre", int'(count), e.pre);
                    @(negedge clk);
                    check("count_post", int'(count), e.post);
                    check("empty_post", int'(empty), int'(e.post == 0));
                    check("door_lock_post", int'(door_lock), int'(e.post == MAX_OCC));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d expected 0", exp_q.size());
        $fatal(1);
    end

    initial begin
        int t0, kind, la, lb;
        reset        = 1'b1;
        pressure_in  = 1'b0;
        pressure_out = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_door_lock", int'(door_lock), 0);
        check("rst_evt_lost", int'(evt_lost), 0);

        // Fill to capacity, then one rejected entry.
        txn(0, 10, 0);
        txn(0, DEB, 0);
        txn(0, 7, 0);
        txn(0, 6, 0);
        repeat (3) txn(1, 6, 0);
        txn(1, 5, 0);

        // Contention: exit wins first, then alternation.
        do_reset();
        txn(0, 6, 0);
        txn(2, 6, 6);
        txn(1, 6, 0);
        txn(2, 8, 5);

        // Short glitch, then a press with single-cycle dropouts.
        txn(3, DEB - 1, 0);
        txn(5, 0, 0);

        // Reset lands while an entry is being served at count 2.
        do_reset();
        txn(0, 5, 0);
        txn(0, 5, 0);
        t0 = cyc;
        pressure_in = 1'b1;
        repeat (5) @(negedge clk);
        pressure_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_serve_no_ack", int'(in_ack), 0);
        check("rst_mid_serve_cycle", cyc, t0 + 8);
        @(negedge clk);
        check("rst_mid_serve_count", int'(count), 0);
        check("rst_mid_serve_empty", int'(empty), 1);
        reset          = 1'b0;
        model_occ      = 0;
        model_last_out = 1'b0;
        repeat (20) @(negedge clk);
        txn(0, 6, 0);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 5);
            la   = (kind == 3 || kind == 4) ? $urandom_range(1, DEB - 1) : $urandom_range(DEB, 12);
            lb   = $urandom_range(DEB, 12);
            txn(kind, la, lb);
        end

        repeat (10) @(negedge clk);
        check("events_outstanding", exp_q.size(), 0);
        check("final_count", int'(count), model_occ);
        check("final_evt_lost", int'(evt_lost), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_occupancy_ctrl.md
# store_occupancy_ctrl

Sequencing controller for the smart-store occupancy counter. It synchronises and debounces the raw entry and exit pressure-mat signals and turns each press into exactly one increment or decrement request. When an entry and an exit arrive together it arbitrates between them, and it enforces the capacity limit (entry door lock) and the empty floor (no underflow). It sits between the pressure-sensor pads and the store display/door logic, and owns the occupancy register.

## Interface
- CNT_W, 5, width of occupancy count
- MAX_OCC, 20, store capacity; must satisfy 1 ≤ MAX_OCC ≤ 2^CNT_W−1
- DEBOUNCE_CYC, 4, consecutive stable samples required to accept a sensor level change; must be ≥ 2
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  reset, synchronous, active-high
- pressure_in  in  1  raw entry-mat level, asynchronous
- pressure_out  in  1  raw exit-mat level, asynchronous
- count  out  CNT_W  current occupancy
- door_lock  out  1  high when count == MAX_OCC
- empty  out  1  high when count == 0
- in_ack  out  1  one-cycle pulse: entry served and counted
- out_ack  out  1  one-cycle pulse: exit served and counted
- in_reject  out  1  one-cycle pulse: entry served while full, not counted
- out_err  out  1  one-cycle pulse: exit served while empty, not counted
- evt_lost  out  1  sticky: a sensor edge arrived while the same direction was still pending; cleared only by reset

## Operation
- Each sensor has its own 2-flop synchroniser and debouncer. The debouncer holds a clean level and a counter. The counter increments while the synchronised level differs from the clean level and clears when they match. When the counter reaches DEBOUNCE_CYC, the clean level flips and the counter clears.
- A rising edge on a clean level sets that direction's pending flag (in_pend / out_pend).
- If a rising edge arrives while that direction's pending flag is already set, the edge is dropped and evt_lost is set.
- FSM states: IDLE, SERVE_IN, SERVE_OUT.
- From IDLE:
  - Only in_pend set → SERVE_IN.
  - Only out_pend set → SERVE_OUT.
  - Both set → round-robin. Serve the direction not served last; the last-served bit resets to "in", so exit wins first after reset.
  - Neither set → stay in IDLE.
- SERVE_IN, for exactly one cycle:
  - If count < MAX_OCC: in_ack = 1 and count+1 on the exiting edge.
  - Otherwise: in_reject = 1 and count unchanged.
  - Clear in_pend, update last-served, return to IDLE.
- SERVE_OUT, symmetric:
  - If count > 0: out_ack = 1 and count−1.
  - Otherwise: out_err = 1 and count unchanged.
  - Clear out_pend, update last-served, return to IDLE.
- A pending flag set on the same edge that clears the other direction is retained.
- Count arithmetic is saturating in both directions; count never leaves 0..MAX_OCC.
- door_lock and empty decode the count register combinationally and are glitch-free relative to count.
- Reset takes priority over everything, including a mid-SERVE state:
  - count = 0, state = IDLE, pending flags = 0, evt_lost = 0, all pulses = 0.
  - Synchronisers and clean levels = 0, debounce counters = 0, last-served = in.
  - Therefore door_lock = 0 and empty = 1 during and after reset.

## Timing
- Uncontended path, counted from the first clock edge that samples the raw sensor high (edge 1):
  - Synchroniser output high at edge 2.
  - Clean level high at edge 2+DEBOUNCE_CYC.
  - Pending set at edge 3+DEBOUNCE_CYC.
  - SERVE entered at edge 4+DEBOUNCE_CYC; the ack/reject pulse is high for that cycle.
  - count updated at edge 5+DEBOUNCE_CYC.
- Contended event is served exactly 2 cycles later than the uncontended one.
- Glitches shorter than DEBOUNCE_CYC cycles on the synchronised signal produce no event.
- Falling edges never generate events.
- Because DEBOUNCE_CYC ≥ 2, two clean rising edges of one sensor are at least 2·DEBOUNCE_CYC cycles apart. This exceeds the worst-case 4-cycle service wait, so evt_lost asserts only on a design or parameter fault.

## Structure
- Shared package store_pkg holds:
  - The FSM state enum (IDLE, SERVE_IN, SERVE_OUT).
  - Default constants CNT_W, MAX_OCC, DEBOUNCE_CYC, reused by the display and door blocks.
- One sub-module, sensor_debounce: synchroniser, debounce counter, clean level and rising-edge pulse. It is instantiated twice.
- Arbiter FSM, count register and status decode live in the top module.

## Test plan
Test parameters: DEBOUNCE_CYC = 4, MAX_OCC = 3.

- Reset, then hold pressure_in high for 10 cycles → in_ack pulses at edge 8, count = 1 at edge 9, empty falls.
- Three entries spaced 20 cycles apart → count 1, 2, 3; door_lock = 1. A fourth entry → in_reject pulse, count stays 3.
- From count = 0, one exit press → out_err pulse, count stays 0, empty stays 1.
- pressure_in and pressure_out rise on the same cycle with count = 1 after reset:
  - out_ack at edge 8 (count = 0).
  - in_ack at edge 10 (count = 1).
  - Repeat → entry served first this time.
- A 3-cycle pulse on pressure_in → no ack, count unchanged. The same press with 1-cycle dropouts → exactly one in_ack.
- Assert reset during SERVE_IN at count = 2 → on the next edge count = 0, no in_ack, state IDLE, empty = 1. A press afterwards counts normally.
